// File: rtl/decode_stage_controller_pkg.sv
// Shared decode constants: RV64IM major opcodes, immediate-format codes and
// the buffer state encoding used by the decode stage and immediate extractor.
package decode_stage_controller_pkg;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;

  // Immediate-format codes shared with the immediate extractor
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_U    = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_UJ   = 3'd5
  } imm_sel_e;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/decode_stage_controller_imm_format_decoder.sv
// Combinational opcode classifier: immediate format and legality (RV64IM).
module imm_format_decoder
  import decode_stage_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  // Map the major opcode to its immediate format; unknown opcodes are illegal
  always_comb begin
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_SYSTEM: imm_sel = IMM_I;
      OP_LUI, OP_AUIPC:                                      imm_sel = IMM_U;
      OP_STORE:                                              imm_sel = IMM_S;
      OP_BRANCH:                                             imm_sel = IMM_B;
      OP_JAL:                                                imm_sel = IMM_UJ;
      OP_OP, OP_OP_32, OP_MISC_MEM:                          imm_sel = IMM_NONE;
      default:                                               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage_controller.sv
// Decode stage controller: two-entry skid buffer between fetch and execute.
// Instructions are classified on entry; the stored classification is
// presented alongside the head instruction from registers.
module decode_stage_controller
  import decode_stage_controller_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [31:0]         IN_INSTRUCTION,
  input  logic [PC_WIDTH-1:0] IN_PC,
  input  logic                FLUSH,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [31:0]         OUT_INSTRUCTION,
  output logic [PC_WIDTH-1:0] OUT_PC,
  output logic [2:0]          IMM_SEL,
  output logic                ILLEGAL
);

  buf_state_e          state;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [31:0]         head_instr;
  logic [PC_WIDTH-1:0] head_pc;
  logic [2:0]          head_imm_sel;
  logic                head_illegal;

  logic [31:0]         skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [2:0]          skid_imm_sel;
  logic                skid_illegal;

  logic [2:0]          dec_imm_sel;
  logic                dec_illegal;
  logic                xfer_in;
  logic                xfer_out;

  imm_format_decoder u_imm_format_decoder (
    .opcode  (IN_INSTRUCTION[6:0]),
    .imm_sel (dec_imm_sel),
    .illegal (dec_illegal)
  );

  assign xfer_in  = IN_VALID & in_ready_q;
  assign xfer_out = out_valid_q & OUT_READY;

  // Buffer FSM: occupancy, handshake flags and head/skid data registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      head_instr   <= '0;
      head_pc      <= '0;
      head_imm_sel <= IMM_NONE;
      head_illegal <= 1'b0;
    end else if (FLUSH) begin
      // A head transfer in this cycle already completed downstream
      state       <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            head_instr   <= IN_INSTRUCTION;
            head_pc      <= IN_PC;
            head_imm_sel <= dec_imm_sel;
            head_illegal <= dec_illegal;
            out_valid_q  <= 1'b1;
            state        <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (xfer_in && !xfer_out) begin
            skid_instr   <= IN_INSTRUCTION;
            skid_pc      <= IN_PC;
            skid_imm_sel <= dec_imm_sel;
            skid_illegal <= dec_illegal;
            in_ready_q   <= 1'b0;
            state        <= ST_FULL;
          end else if (xfer_in && xfer_out) begin
            head_instr   <= IN_INSTRUCTION;
            head_pc      <= IN_PC;
            head_imm_sel <= dec_imm_sel;
            head_illegal <= dec_illegal;
          end else if (xfer_out) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer_out) begin
            head_instr   <= skid_instr;
            head_pc      <= skid_pc;
            head_imm_sel <= skid_imm_sel;
            head_illegal <= skid_illegal;
            in_ready_q   <= 1'b1;
            state        <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY        = in_ready_q;
  assign OUT_VALID       = out_valid_q;
  assign OUT_INSTRUCTION = head_instr;
  assign OUT_PC          = head_pc;
  assign IMM_SEL         = head_imm_sel;
  assign ILLEGAL         = head_illegal;

endmodule

// File: tb/tb_decode_stage_controller.sv
// Scoreboard bench for decode_stage_controller: directed scenarios followed
// by randomized traffic against a capacity-2 FIFO reference model.
module tb_decode_stage_controller;

  localparam int unsigned PCW = 64;

  logic           CLK;
  logic           RESET;
  logic           IN_VALID;
  logic           IN_READY;
  logic [31:0]    IN_INSTRUCTION;
  logic [PCW-1:0] IN_PC;
  logic           FLUSH;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [31:0]    OUT_INSTRUCTION;
  logic [PCW-1:0] OUT_PC;
  logic [2:0]     IMM_SEL;
  logic           ILLEGAL;

  decode_stage_controller #(.PC_WIDTH(PCW)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IN_VALID        (IN_VALID),
    .IN_READY        (IN_READY),
    .IN_INSTRUCTION  (IN_INSTRUCTION),
    .IN_PC           (IN_PC),
    .FLUSH           (FLUSH),
    .OUT_VALID       (OUT_VALID),
    .OUT_READY       (OUT_READY),
    .OUT_INSTRUCTION (OUT_INSTRUCTION),
    .OUT_PC          (OUT_PC),
    .IMM_SEL         (IMM_SEL),
    .ILLEGAL         (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  logic   was_reset = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification straight from the opcode table
  function automatic logic [3:0] ref_decode(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: return {3'd1, 1'b0};
      7'b0110111, 7'b0010111:                                     return {3'd2, 1'b0};
      7'b0100011:                                                 return {3'd3, 1'b0};
      7'b1100011:                                                 return {3'd4, 1'b0};
      7'b1101111:                                                 return {3'd5, 1'b0};
      7'b0110011, 7'b0111011, 7'b0001111:                         return {3'd0, 1'b0};
      default:                                                    return {3'd0, 1'b1};
    endcase
  endfunction

  // Monitor / scoreboard: sampled mid-cycle, mirrors what the DUT sees at the next edge
  always @(negedge CLK) begin
    logic       can_accept;
    logic [3:0] dec;
    entry_t     e;
    if (RESET) begin
      exp_q.delete();
      was_reset = 1'b1;
    end else begin
      if (was_reset) begin
        chk("reset_out_instruction", 64'(OUT_INSTRUCTION), 64'h0);
        chk("reset_out_pc", 64'(OUT_PC), 64'h0);
        chk("reset_imm_sel", 64'(IMM_SEL), 64'h0);
        chk("reset_illegal", 64'(ILLEGAL), 64'h0);
        was_reset = 1'b0;
      end
      can_accept = (exp_q.size() < 2);
      chk("in_ready", 64'(IN_READY), 64'(can_accept));
      chk("out_valid", 64'(OUT_VALID), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e   = exp_q[0];
        dec = ref_decode(e.instr);
        chk("out_instruction", 64'(OUT_INSTRUCTION), 64'(e.instr));
        chk("out_pc", 64'(OUT_PC), 64'(e.pc));
        chk("imm_sel", 64'(IMM_SEL), 64'(dec[3:1]));
        chk("illegal", 64'(ILLEGAL), 64'(dec[0]));
        if (OUT_READY) void'(exp_q.pop_front());
      end
      if (FLUSH) exp_q.delete();
      else if (IN_VALID && can_accept) begin
        e.instr = IN_INSTRUCTION;
        e.pc    = IN_PC;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                       input logic ordy, input logic fl, input logic rst);
    IN_VALID       = v;
    IN_INSTRUCTION = ins;
    IN_PC          = pc;
    OUT_READY      = ordy;
    FLUSH          = fl;
    RESET          = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [6:0] op_pool [14];
  initial begin
    op_pool = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011,
                7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b0110011, 7'b0111011, 7'b0001111, 7'b1111111};
  end

  initial begin
    logic [31:0] ins;
    int unsigned k;
    IN_VALID = 1'b0; IN_INSTRUCTION = '0; IN_PC = '0;
    OUT_READY = 1'b0; FLUSH = 1'b0; RESET = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // addi, single transfer
    drive(1'b1, 32'h00500093, 64'h100, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Backpressure fill: lui, sw, then branch waits for space
    drive(1'b1, 32'h123452B7, 64'h200, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00A12023, 64'h204, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFE000EE3, 64'h208, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFE000EE3, 64'h208, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'hFE000EE3, 64'h208, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Streaming jal
    for (int unsigned i = 0; i < 8; i++)
      drive(1'b1, 32'h0080006F, 64'(64'h300 + 4 * i), 1'b1, 1'b0, 1'b0);
    idle(2);

    // Flush while full with a concurrent input
    drive(1'b1, 32'h00100113, 64'h500, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200193, 64'h504, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300213, 64'h508, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Illegal word and mul
    drive(1'b1, 32'hFFFFFFFF, 64'h400, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h02B50533, 64'h404, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Reset while full and stalled
    drive(1'b1, 32'h00100113, 64'h600, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200193, 64'h604, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300213, 64'h608, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      k   = $urandom_range(0, 14);
      ins = $urandom;
      if (k < 14) ins[6:0] = op_pool[k];
      drive(1'($urandom_range(0, 3) != 0), ins, {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 150) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_controller.md
DECODE_STAGE_CONTROLLER -- requirements
Module: decode_stage_controller

Interface
REQ-001 Parameter PC_WIDTH, default 64, width of the program-counter field carried with each instruction.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 IN_VALID  input  1  fetch side presents an instruction.
REQ-005 IN_READY  output  1  controller can accept an instruction this cycle.
REQ-006 IN_INSTRUCTION  input  32  fetched instruction word.
REQ-007 IN_PC  input  PC_WIDTH  address of IN_INSTRUCTION.
REQ-008 FLUSH  input  1  discard all buffered instructions (branch redirect).
REQ-009 OUT_VALID  output  1  decoded instruction available to the execute stage.
REQ-010 OUT_READY  input  1  execute stage accepts the head instruction.
REQ-011 OUT_INSTRUCTION  output  32  head instruction word, which drives the immediate extractor INSTRUCTION input.
REQ-012 OUT_PC  output  PC_WIDTH  head instruction PC.
REQ-013 IMM_SEL  output  3  immediate-format code for the extractor: 0 none, 1 I, 2 U, 3 S, 4 B, 5 UJ.
REQ-014 ILLEGAL  output  1  head opcode is not RV64IM.

Function
REQ-015 Decode: opcode[6:0] 0000011/0010011/0011011/1100111/1110011 -> 1; 0110111/0010111 -> 2; 0100011 -> 3; 1100011 -> 4; 1101111 -> 5; 0110011/0111011/0001111 -> 0; any other -> 0 with ILLEGAL=1.
REQ-016 Decode at enqueue; IMM_SEL and ILLEGAL are stored with each entry and output from registers, never combinationally from IN_INSTRUCTION.
REQ-017 Buffer: two-entry skid (head register + skid register); states EMPTY, ONE, FULL.
REQ-018 Transfer in = IN_VALID & IN_READY; transfer out = OUT_VALID & OUT_READY.
REQ-019 IN_READY is a registered output, equal to 1 in EMPTY and ONE and 0 in FULL.
REQ-020 OUT_VALID = 1 in ONE and FULL; outputs reflect the head entry.
REQ-021 EMPTY: in -> ONE; next cycle the accepted entry is at head (latency 1 cycle).
REQ-022 ONE: in without out -> FULL (new entry to skid); out without in -> EMPTY; in and out together -> ONE, new entry becomes head.
REQ-023 FULL: out -> ONE, skid moves to head; no input is accepted.
REQ-024 Order is strictly FIFO; no entry is dropped or duplicated except on FLUSH.
REQ-025 OUT_INSTRUCTION, OUT_PC, IMM_SEL and ILLEGAL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 FLUSH has priority: next state EMPTY, any simultaneous input transfer is discarded, and IN_READY=1 on the next cycle.
REQ-027 Output transfer in the FLUSH cycle completes normally; downstream owns that instruction.
REQ-028 In EMPTY, outputs are don't-care except OUT_VALID=0, and the data registers are not required to clear.

Reset
REQ-029 On RESET: state EMPTY, OUT_VALID=0, IN_READY=1, IMM_SEL=0, ILLEGAL=0, OUT_INSTRUCTION=0, OUT_PC=0.
REQ-030 RESET mid-operation discards all buffered entries and overrides FLUSH and IN_VALID in the same cycle.

Structure
REQ-031 A shared package holds the opcode constants, the IMM_SEL codes (NONE=0, I=1, U=2, S=3, B=4, UJ=5) and the state encoding; the immediate extractor uses the same code constants.
REQ-032 One combinational sub-module, imm_format_decoder (opcode in; IMM_SEL and ILLEGAL out), is instantiated once at the input side.

Verification
REQ-033 Reset, then IN_VALID with 0x00500093 (addi), PC 0x100, OUT_READY=1 -> next cycle OUT_VALID=1, IMM_SEL=1, OUT_PC=0x100, ILLEGAL=0.
REQ-034 OUT_READY=0 and three consecutive valid inputs (0x123452B7, 0x00A12023, 0xFE000EE3) -> IN_READY falls after the second; after OUT_READY=1 the outputs are IMM_SEL 2, 3, 4 in order, and the third is then accepted.
REQ-035 Streaming with IN_VALID=OUT_READY=1 for 8 cycles of jal 0x0080006F -> one output per cycle, IMM_SEL=5, PC order preserved.
REQ-036 FULL state plus FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0 and IN_READY=1; the flushed and concurrent inputs never appear.
REQ-037 Input 0xFFFFFFFF -> IMM_SEL=0, ILLEGAL=1; input 0x02B50533 (mul) -> IMM_SEL=0, ILLEGAL=0.
REQ-038 RESET asserted while FULL with OUT_READY=0 -> next cycle all outputs at reset values.
